// File: rtl/aes_axil_slave_if.sv
// aes_axil_slave_if: AXI4-Lite bus bundle between a host master and the AES register slave
// Ports: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready), B (bresp/bvalid/bready),
//        AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/rready); master and slave modports.
interface aes_axil_slave_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] awaddr;
  logic awvalid;
  logic awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [ADDR_W-1:0] araddr;
  logic arvalid;
  logic arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/aes_axil_slave.sv
// aes_axil_slave: AXI4-Lite slave turning bus writes/reads into register-file strobes
// Ports: clk, reset (async, active-high); s_axi (AXI4-Lite slave bundle);
//        wr_en/wr_addr/wr_data one-cycle write strobe; rd_en/rd_addr fetch with combinational rd_data.
module aes_axil_slave #(
  parameter int ADDR_W = 32,
  parameter int WIN_BITS = 8
) (
  input logic clk,
  input logic reset,
  aes_axil_slave_if.slave s_axi,
  output logic wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0] wr_data,
  output logic rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input logic [31:0] rd_data
);
  typedef enum logic [1:0] {W_IDLE, W_PULSE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_t;
  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, rd_addr_q, rd_addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d, w_resp, r_resp;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic aw_hs, w_hs, ar_hs;
  // Out-of-window (DECERR) takes priority over misalignment/partial strobe (SLVERR)
  function automatic logic [1:0] resp_of(input logic [ADDR_W-1:0] a, input logic strb_ok);
    return |a[ADDR_W-1:WIN_BITS] ? 2'b11 : (a[1:0] != 2'b00 || !strb_ok) ? 2'b10 : 2'b00;
  endfunction
  assign s_axi.awready = w_state_q == W_IDLE && !aw_full_q;
  assign s_axi.wready = w_state_q == W_IDLE && !w_full_q;
  assign s_axi.arready = r_state_q == R_IDLE;
  assign s_axi.bvalid = bvalid_q;
  assign s_axi.bresp = bresp_q;
  assign s_axi.rvalid = rvalid_q;
  assign s_axi.rdata = rdata_q;
  assign s_axi.rresp = rresp_q;
  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs = s_axi.wvalid && s_axi.wready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign w_resp = resp_of(awaddr_q, wstrb_q == 4'hF);
  assign r_resp = resp_of(rd_addr_q, 1'b1);
  assign wr_en = wr_en_q;
  assign wr_addr = awaddr_q;
  assign wr_data = wdata_q;
  assign rd_en = rd_en_q;
  assign rd_addr = rd_addr_q;
  always_comb begin
    w_state_d = w_state_q;
    aw_full_d = aw_full_q;
    w_full_d = w_full_q;
    awaddr_d = awaddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    bresp_d = bresp_q;
    bvalid_d = bvalid_q;
    wr_en_d = 1'b0;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d = s_axi.awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d = s_axi.wdata;
      wstrb_d = s_axi.wstrb;
    end
    if (w_state_q == W_IDLE && aw_full_q && w_full_q) begin
      w_state_d = w_resp == 2'b00 ? W_PULSE : W_RESP;
      wr_en_d = w_resp == 2'b00;
      bvalid_d = w_resp != 2'b00;
      bresp_d = w_resp;
    end else if (w_state_q == W_PULSE) begin
      w_state_d = W_RESP;
      bvalid_d = 1'b1;
      bresp_d = 2'b00;
    end else if (w_state_q == W_RESP && s_axi.bready) begin
      w_state_d = W_IDLE;
      bvalid_d = 1'b0;
      aw_full_d = 1'b0;
      w_full_d = 1'b0;
    end
  end
  always_comb begin
    r_state_d = r_state_q;
    rd_addr_d = rd_addr_q;
    rd_en_d = 1'b0;
    rvalid_d = rvalid_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      r_state_d = R_FETCH;
      rd_addr_d = s_axi.araddr;
      rd_en_d = 1'b1;
    end else if (r_state_q == R_FETCH) begin
      r_state_d = R_RESP;
      rvalid_d = 1'b1;
      rresp_d = r_resp;
      rdata_d = r_resp == 2'b00 ? rd_data : 32'h0;
    end else if (r_state_q == R_RESP && s_axi.rready) begin
      r_state_d = R_IDLE;
      rvalid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_full_q <= 1'b0;
      w_full_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= '0;
      bvalid_q <= 1'b0;
      wr_en_q <= 1'b0;
      rd_addr_q <= '0;
      rd_en_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_full_q <= aw_full_d;
      w_full_q <= w_full_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bresp_q <= bresp_d;
      bvalid_q <= bvalid_d;
      wr_en_q <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q <= rd_en_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end
endmodule

// File: tb/tb_aes_axil_slave.sv
// tb_aes_axil_slave: directed self-checking bench for aes_axil_slave
module tb_aes_axil_slave;
  logic clk = 1'b0;
  logic reset;
  logic wr_en, rd_en;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int base;
  bit consec = 1'b0;
  bit prev_we = 1'b0;
  logic [31:0] wa_q[$];
  logic [31:0] ea [4] = '{32'h12, 32'h110, 32'h14, 32'h113};
  logic [3:0] es [4] = '{4'hF, 4'hF, 4'h3, 4'h3};
  logic [1:0] er [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
  aes_axil_slave_if #(.ADDR_W(32)) s_axi ();
  aes_axil_slave #(.ADDR_W(32), .WIN_BITS(8)) dut (
    .clk(clk), .reset(reset), .s_axi(s_axi),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      wa_q.push_back(wr_addr);
      if (prev_we) consec = 1'b1;
    end
    prev_we = wr_en;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    s_axi.awaddr = a;
    s_axi.awvalid = 1'b1;
    s_axi.wdata = d;
    s_axi.wstrb = s;
    s_axi.wvalid = 1'b1;
    tick();
    s_axi.awvalid = 1'b0;
    s_axi.wvalid = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    s_axi.awaddr = '0;
    s_axi.awvalid = 1'b0;
    s_axi.wdata = '0;
    s_axi.wstrb = '0;
    s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b0;
    s_axi.araddr = '0;
    s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b0;
    rd_data = '0;
    #2;
    chk("rst_awready", 32'(s_axi.awready), 1);
    chk("rst_wready", 32'(s_axi.wready), 1);
    chk("rst_arready", 32'(s_axi.arready), 1);
    chk("rst_bvalid", 32'(s_axi.bvalid), 0);
    chk("rst_rvalid", 32'(s_axi.rvalid), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_wr_addr", wr_addr, 0);
    tick();
    reset = 1'b0;
    s_axi.bready = 1'b1;
    base = wr_cnt;
    do_write(32'h10, 32'hDEADBEEF, 4'hF);
    chk("w1_e0_wr_en", 32'(wr_en), 0);
    chk("w1_e0_awready", 32'(s_axi.awready), 0);
    tick();
    chk("w1_e1_wr_en", 32'(wr_en), 1);
    chk("w1_e1_wr_addr", wr_addr, 32'h10);
    chk("w1_e1_wr_data", wr_data, 32'hDEADBEEF);
    chk("w1_e1_bvalid", 32'(s_axi.bvalid), 0);
    tick();
    chk("w1_e2_wr_en", 32'(wr_en), 0);
    chk("w1_e2_bvalid", 32'(s_axi.bvalid), 1);
    chk("w1_e2_bresp", 32'(s_axi.bresp), 0);
    tick();
    chk("w1_e3_bvalid", 32'(s_axi.bvalid), 0);
    chk("w1_e3_awready", 32'(s_axi.awready), 1);
    chk("w1_pulses", wr_cnt - base, 1);
    base = wr_cnt;
    s_axi.wdata = 32'hCAFEF00D;
    s_axi.wstrb = 4'hF;
    s_axi.wvalid = 1'b1;
    tick();
    s_axi.wvalid = 1'b0;
    chk("w2_wready", 32'(s_axi.wready), 0);
    chk("w2_awready", 32'(s_axi.awready), 1);
    tick();
    tick();
    chk("w2_idle_wr_en", 32'(wr_en), 0);
    s_axi.awaddr = 32'h24;
    s_axi.awvalid = 1'b1;
    tick();
    s_axi.awvalid = 1'b0;
    chk("w2_e0_wr_en", 32'(wr_en), 0);
    tick();
    chk("w2_e1_wr_en", 32'(wr_en), 1);
    chk("w2_e1_wr_addr", wr_addr, 32'h24);
    chk("w2_e1_wr_data", wr_data, 32'hCAFEF00D);
    tick();
    chk("w2_e2_bvalid", 32'(s_axi.bvalid), 1);
    tick();
    chk("w2_e3_bvalid", 32'(s_axi.bvalid), 0);
    chk("w2_pulses", wr_cnt - base, 1);
    rd_data = 32'h5;
    s_axi.araddr = 32'h08;
    s_axi.arvalid = 1'b1;
    tick();
    s_axi.arvalid = 1'b0;
    chk("r1_e0_rd_en", 32'(rd_en), 1);
    chk("r1_e0_rd_addr", rd_addr, 32'h08);
    chk("r1_e0_arready", 32'(s_axi.arready), 0);
    chk("r1_e0_rvalid", 32'(s_axi.rvalid), 0);
    tick();
    rd_data = 32'h77;
    chk("r1_e1_rd_en", 32'(rd_en), 0);
    chk("r1_e1_rvalid", 32'(s_axi.rvalid), 1);
    chk("r1_e1_rdata", s_axi.rdata, 32'h5);
    chk("r1_e1_rresp", 32'(s_axi.rresp), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r1_hold_rvalid", 32'(s_axi.rvalid), 1);
      chk("r1_hold_rdata", s_axi.rdata, 32'h5);
      chk("r1_hold_arready", 32'(s_axi.arready), 0);
      chk("r1_hold_rd_en", 32'(rd_en), 0);
    end
    s_axi.rready = 1'b1;
    tick();
    s_axi.rready = 1'b0;
    chk("r1_done_rvalid", 32'(s_axi.rvalid), 0);
    chk("r1_done_arready", 32'(s_axi.arready), 1);
    for (int i = 0; i < 4; i++) begin
      base = wr_cnt;
      do_write(ea[i], 32'h1111, es[i]);
      tick();
      chk("werr_bvalid", 32'(s_axi.bvalid), 1);
      chk("werr_bresp", 32'(s_axi.bresp), 32'(er[i]));
      chk("werr_wr_en", 32'(wr_en), 0);
      tick();
      chk("werr_done_bvalid", 32'(s_axi.bvalid), 0);
      chk("werr_pulses", wr_cnt - base, 0);
    end
    rd_data = 32'hFFFFFFFF;
    s_axi.rready = 1'b1;
    s_axi.araddr = 32'h200;
    s_axi.arvalid = 1'b1;
    tick();
    s_axi.arvalid = 1'b0;
    chk("rerr_rd_en", 32'(rd_en), 1);
    tick();
    chk("rerr_rvalid", 32'(s_axi.rvalid), 1);
    chk("rerr_rresp", 32'(s_axi.rresp), 3);
    chk("rerr_rdata", s_axi.rdata, 0);
    tick();
    chk("rerr_done_rvalid", 32'(s_axi.rvalid), 0);
    s_axi.rready = 1'b0;
    base = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      do_write(32'h20 + 32'(4 * i), 32'h100 + 32'(i), 4'hF);
      tick();
      tick();
      tick();
    end
    chk("b2b_pulses", wr_cnt - base, 4);
    for (int i = 0; i < 4; i++) chk("b2b_addr", wa_q[base + i], 32'h20 + 32'(4 * i));
    s_axi.bready = 1'b0;
    s_axi.awaddr = 32'h40;
    s_axi.awvalid = 1'b1;
    s_axi.wdata = 32'h1234;
    s_axi.wstrb = 4'hF;
    s_axi.wvalid = 1'b1;
    s_axi.araddr = 32'h04;
    s_axi.arvalid = 1'b1;
    tick();
    s_axi.awvalid = 1'b0;
    s_axi.wvalid = 1'b0;
    s_axi.arvalid = 1'b0;
    tick();
    chk("rst_pre_wr_en", 32'(wr_en), 1);
    chk("rst_pre_rvalid", 32'(s_axi.rvalid), 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_wr_en", 32'(wr_en), 0);
    chk("rst_mid_bvalid", 32'(s_axi.bvalid), 0);
    chk("rst_mid_rvalid", 32'(s_axi.rvalid), 0);
    chk("rst_mid_awready", 32'(s_axi.awready), 1);
    chk("rst_mid_arready", 32'(s_axi.arready), 1);
    #1 reset = 1'b0;
    tick();
    tick();
    chk("rst_post_bvalid", 32'(s_axi.bvalid), 0);
    chk("rst_post_rvalid", 32'(s_axi.rvalid), 0);
    chk("rst_post_wr_en", 32'(wr_en), 0);
    s_axi.bready = 1'b1;
    base = wr_cnt;
    do_write(32'h0C, 32'hC0FFEE, 4'hF);
    tick();
    chk("fresh_wr_en", 32'(wr_en), 1);
    chk("fresh_wr_addr", wr_addr, 32'h0C);
    chk("fresh_wr_data", wr_data, 32'hC0FFEE);
    tick();
    chk("fresh_bvalid", 32'(s_axi.bvalid), 1);
    chk("fresh_bresp", 32'(s_axi.bresp), 0);
    tick();
    chk("fresh_done_bvalid", 32'(s_axi.bvalid), 0);
    chk("fresh_pulses", wr_cnt - base, 1);
    chk("no_b2b_wr_en", 32'(consec), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
